// File: rtl/seq_compare.sv
// Multi-cycle magnitude/equality comparator, scanning operands MSB-first one chunk per cycle.
// Optional build macro SEQ_COMPARE_EARLY_EXIT_EN: leave SCAN as soon as the first differing chunk is seen.
module seq_compare #(
    parameter int unsigned BUS_SIZE   = 16,
    parameter int unsigned CHUNK_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic [1:0]          mode,
    input  logic                is_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                res,
    output logic                eq,
    output logic                lt
);

    localparam int unsigned N     = BUS_SIZE / CHUNK_SIZE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    if (CHUNK_SIZE == 0 || (BUS_SIZE % CHUNK_SIZE) != 0 || N < 1) begin : g_bad_params
        $error("seq_compare: BUS_SIZE must be a non-zero multiple of CHUNK_SIZE");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [BUS_SIZE-1:0] a_q, a_d;
    logic [BUS_SIZE-1:0] b_q, b_d;
    logic [1:0]          mode_q, mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                decided_q, decided_d;
    logic                lt_r_q, lt_r_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                res_q, res_d;
    logic                eq_q, eq_d;
    logic                lt_q, lt_d;

    logic [CHUNK_SIZE-1:0] a_chunk_c;
    logic [CHUNK_SIZE-1:0] b_chunk_c;
    logic                  scan_done_c;

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        decided_d   = decided_q;
        lt_r_d      = lt_r_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        scan_done_c = 1'b0;

        a_chunk_c = CHUNK_SIZE'(a_q >> (32'(idx_q) * CHUNK_SIZE));
        b_chunk_c = CHUNK_SIZE'(b_q >> (32'(idx_q) * CHUNK_SIZE));

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Flipping both sign bits turns a signed compare into an unsigned one
                    a_d       = a;
                    b_d       = b;
                    if (is_signed) begin
                        a_d[BUS_SIZE-1] = ~a[BUS_SIZE-1];
                        b_d[BUS_SIZE-1] = ~b[BUS_SIZE-1];
                    end
                    mode_d    = mode;
                    idx_d     = IDX_W'(N - 1);
                    decided_d = 1'b0;
                    lt_r_d    = 1'b0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!decided_q && (a_chunk_c != b_chunk_c)) begin
                    decided_d = 1'b1;
                    lt_r_d    = (a_chunk_c < b_chunk_c);
                end
                idx_d       = idx_q - IDX_W'(1);
`ifdef SEQ_COMPARE_EARLY_EXIT_EN
                scan_done_c = (idx_q == '0) || decided_d;
`else
                scan_done_c = (idx_q == '0);
`endif
                if (scan_done_c) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    eq_d        = !decided_d;
                    lt_d        = lt_r_d;
                    case (mode_q)
                        2'b00:   res_d = !decided_d;
                        2'b01:   res_d = decided_d;
                        2'b10:   res_d = lt_r_d;
                        default: res_d = !lt_r_d;
                    endcase
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    res_d       = 1'b0;
                    eq_d        = 1'b0;
                    lt_d        = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= '0;
            idx_q       <= '0;
            decided_q   <= 1'b0;
            lt_r_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            decided_q   <= decided_d;
            lt_r_q      <= lt_r_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign eq        = eq_q;
    assign lt        = lt_q;

endmodule
